// File: rtl/qpi_tx_arbiter_if.sv
// rtl/qpi_tx_arbiter_if.sv - request/grant and CCI TX channel bundle for qpi_tx_arbiter.
interface qpi_tx_arbiter_if #(
  parameter int HDR_W  = 61,
  parameter int DATA_W = 512
);
  logic              rdr_rd_req;
  logic [HDR_W-1:0]  rdr_rd_hdr;
  logic              wtr_rd_req;
  logic [HDR_W-1:0]  wtr_rd_hdr;
  logic              rdr_wr_req;
  logic [HDR_W-1:0]  rdr_wr_hdr;
  logic [DATA_W-1:0] rdr_wr_data;
  logic              wtr_wr_req;
  logic [HDR_W-1:0]  wtr_wr_hdr;
  logic [DATA_W-1:0] wtr_wr_data;
  logic              tx0_almostfull;
  logic              tx1_almostfull;
  logic              rdr_rd_grant;
  logic              wtr_rd_grant;
  logic              rdr_wr_grant;
  logic              wtr_wr_grant;
  logic [HDR_W-1:0]  tx0_header;
  logic              tx0_rdvalid;
  logic [HDR_W-1:0]  tx1_header;
  logic [DATA_W-1:0] tx1_data;
  logic              tx1_wrvalid;
  logic              rd_type_err;

  modport master (
    input  rdr_rd_req, rdr_rd_hdr, wtr_rd_req, wtr_rd_hdr,
    input  rdr_wr_req, rdr_wr_hdr, rdr_wr_data,
    input  wtr_wr_req, wtr_wr_hdr, wtr_wr_data,
    input  tx0_almostfull, tx1_almostfull,
    output rdr_rd_grant, wtr_rd_grant, rdr_wr_grant, wtr_wr_grant,
    output tx0_header, tx0_rdvalid, tx1_header, tx1_data, tx1_wrvalid,
    output rd_type_err
  );

  modport slave (
    output rdr_rd_req, rdr_rd_hdr, wtr_rd_req, wtr_rd_hdr,
    output rdr_wr_req, rdr_wr_hdr, rdr_wr_data,
    output wtr_wr_req, wtr_wr_hdr, wtr_wr_data,
    output tx0_almostfull, tx1_almostfull,
    input  rdr_rd_grant, wtr_rd_grant, rdr_wr_grant, wtr_wr_grant,
    input  tx0_header, tx0_rdvalid, tx1_header, tx1_data, tx1_wrvalid,
    input  rd_type_err
  );
endinterface

// File: rtl/qpi_tx_arbiter.sv
// rtl/qpi_tx_arbiter.sv - round-robin reader/writer arbiter onto CCI TX ch0 (reads) and ch1 (writes).
// Optional stall counters under QPI_TX_ARB_PERF_EN.
module qpi_tx_arbiter #(
  parameter int HDR_W  = 61,
  parameter int DATA_W = 512
) (
  input  logic                 clk,
  input  logic                 resetb,
  qpi_tx_arbiter_if.master     bus
`ifdef QPI_TX_ARB_PERF_EN
  ,
  output logic [31:0]          perf_ch0_stall,
  output logic [31:0]          perf_ch1_stall
`endif
);

  logic             g_rr, g_wr, g_rw, g_ww;
  logic             g0, g1;
  logic             last0_wtr, last1_wtr;
  logic [HDR_W-1:0] sel_hdr0;

  // Grants are qualified by resetb so nothing is accepted while reset is held.
  always_comb begin
    g_rr = 1'b0;
    g_wr = 1'b0;
    g_rw = 1'b0;
    g_ww = 1'b0;
    if (resetb && !bus.tx0_almostfull) begin
      if (bus.rdr_rd_req && bus.wtr_rd_req) begin
        g_rr = last0_wtr;
        g_wr = !last0_wtr;
      end else begin
        g_rr = bus.rdr_rd_req;
        g_wr = bus.wtr_rd_req;
      end
    end
    if (resetb && !bus.tx1_almostfull) begin
      if (bus.rdr_wr_req && bus.wtr_wr_req) begin
        g_rw = last1_wtr;
        g_ww = !last1_wtr;
      end else begin
        g_rw = bus.rdr_wr_req;
        g_ww = bus.wtr_wr_req;
      end
    end
  end

  assign g0 = g_rr | g_wr;
  assign g1 = g_rw | g_ww;

  assign bus.rdr_rd_grant = g_rr;
  assign bus.wtr_rd_grant = g_wr;
  assign bus.rdr_wr_grant = g_rw;
  assign bus.wtr_wr_grant = g_ww;

  // mdata[12] carries the is_read tag: 1 for reader-sourced reads.
  assign sel_hdr0 = g_rr ? {bus.rdr_rd_hdr[HDR_W-1:13], 1'b1, bus.rdr_rd_hdr[11:0]}
                         : {bus.wtr_rd_hdr[HDR_W-1:13], 1'b0, bus.wtr_rd_hdr[11:0]};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      last0_wtr       <= 1'b1;
      last1_wtr       <= 1'b1;
      bus.tx0_rdvalid <= 1'b0;
      bus.tx0_header  <= '0;
      bus.tx1_wrvalid <= 1'b0;
      bus.tx1_header  <= '0;
      bus.tx1_data    <= '0;
      bus.rd_type_err <= 1'b0;
    end else begin
      bus.tx0_rdvalid <= g0;
      bus.tx1_wrvalid <= g1;
      if (g0) begin
        last0_wtr      <= g_wr;
        bus.tx0_header <= sel_hdr0;
        if (sel_hdr0[55:52] != 4'h4)
          bus.rd_type_err <= 1'b1;
      end
      if (g1) begin
        last1_wtr      <= g_ww;
        bus.tx1_header <= g_rw ? bus.rdr_wr_hdr  : bus.wtr_wr_hdr;
        bus.tx1_data   <= g_rw ? bus.rdr_wr_data : bus.wtr_wr_data;
      end
    end
  end

`ifdef QPI_TX_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      perf_ch0_stall <= '0;
      perf_ch1_stall <= '0;
    end else begin
      if ((bus.rdr_rd_req || bus.wtr_rd_req) && bus.tx0_almostfull)
        perf_ch0_stall <= perf_ch0_stall + 32'd1;
      if ((bus.rdr_wr_req || bus.wtr_wr_req) && bus.tx1_almostfull)
        perf_ch1_stall <= perf_ch1_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/qpi_tx_arbiter.md
Name: qpi_tx_arbiter

Overview:
Sits directly downstream of the frame reader and frame writer, in front of the CCI TX channels. Arbitrates their read requests onto TX channel 0 and their write requests onto TX channel 1, honouring channel almostfull back-pressure. Each channel uses independent round-robin arbitration. TX outputs are registered.

Parameters:
HDR_W, 61, TX header width (byte_enable[60:56], request_type[55:52], rsvd[51:46], address[45:14], mdata[13:0])
DATA_W, 512, cache-line width

Ports:
clk  in  1  clock
resetb  in  1  asynchronous active-low reset
rdr_rd_req  in  1  frame reader requests a read
rdr_rd_hdr  in  HDR_W  frame reader read header
wtr_rd_req  in  1  frame writer requests a read
wtr_rd_hdr  in  HDR_W  frame writer read header
rdr_wr_req  in  1  frame reader requests a write
rdr_wr_hdr  in  HDR_W  frame reader write header
rdr_wr_data  in  DATA_W  frame reader write data
wtr_wr_req  in  1  frame writer requests a write
wtr_wr_hdr  in  HDR_W  frame writer write header
wtr_wr_data  in  DATA_W  frame writer write data
tx0_almostfull  in  1  channel 0 back-pressure
tx1_almostfull  in  1  channel 1 back-pressure
rdr_rd_grant  out  1  reader read accepted this cycle
wtr_rd_grant  out  1  writer read accepted this cycle
rdr_wr_grant  out  1  reader write accepted this cycle
wtr_wr_grant  out  1  writer write accepted this cycle
tx0_header  out  HDR_W  channel 0 header
tx0_rdvalid  out  1  channel 0 valid
tx1_header  out  HDR_W  channel 1 header
tx1_data  out  DATA_W  channel 1 data
tx1_wrvalid  out  1  channel 1 valid
rd_type_err  out  1  sticky: a non-RdLine header was granted on channel 0

Behaviour:
- One clock. Reset is asynchronous and active-low on resetb.
- Reset values:
  - all valids, grants and rd_type_err are 0
  - tx headers and data are 0
  - round-robin pointers point to the writer, so the reader wins the first contention
- Grants are combinational, in the same cycle as the request. A request is consumed exactly when its grant is 1. The requester must hold its request, header and data stable until granted.
- Per channel, at most one grant per cycle. Grant only when the channel's almostfull is 0 (sampled the same cycle). While almostfull is 1, no grant and the valid output goes to 0 next cycle.
- Arbitration per channel:
  - single requester: grant it
  - both requesting: grant the source not granted last
  - the pointer updates only on a grant
- Output stage:
  - a grant in cycle N registers the header (and data on ch1) and drives valid=1 in cycle N+1
  - no grant in cycle N gives valid=0 in N+1; header and data hold their previous value
  - latency is 1 cycle; sustained throughput is 1 per cycle per channel
- Channel 0 metadata tag: the arbiter overwrites mdata[12] (is_read) with 1 for reader-sourced reads and 0 for writer-sourced reads. All other header bits pass unchanged.
- Channel 1 headers and data pass unchanged.
- rd_type_err: set on a ch0 grant whose request_type (bits 55:52) is not 4'h4. It is cleared only by reset.
- Channels are fully independent; simultaneous grants on both channels are allowed.
- Reset asserted mid-operation: outputs clear immediately and any pending requests are not granted. Requesters re-present them after reset.

Optional Feature:
QPI_TX_ARB_PERF_EN
- Defined: adds outputs perf_ch0_stall[31:0] and perf_ch1_stall[31:0].
  - each counts cycles in which its channel had at least one request but almostfull=1
  - counters wrap at 2^32
  - counters reset to 0
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- After reset, rdr_rd_req=1 and wtr_rd_req=1 held for 4 cycles, almostfull=0 -> grants alternate rdr,wtr,rdr,wtr. tx0_rdvalid=1 from cycle 2 to 5. mdata[12] is 1,0,1,0.
- rdr_wr_req with hdr type 4'h2, data 0xA5..A5, tx1_almostfull=1 for 3 cycles then 0 -> no grant and tx1_wrvalid=0 while almostfull is high. Grant arrives in cycle 4; tx1_wrvalid=1 with data 0xA5..A5 in cycle 5.
- wtr_rd_req and rdr_wr_req in the same cycle -> both granted. tx0_rdvalid and tx1_wrvalid are both 1 the next cycle.
- Granted ch0 header with type 4'h2 -> rd_type_err=1 the next cycle and stays 1 until resetb=0.
- resetb pulsed low while both channels are streaming -> all valids and grants read 0 during reset. The first contention after reset goes to the reader.
- With QPI_TX_ARB_PERF_EN defined: a request held for 10 cycles under tx0_almostfull=1 -> perf_ch0_stall=10 and perf_ch1_stall=0.
